// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: address width, almost-full default and the
// binary/Gray conversions used by both the write and read controllers.
package fifo_pkg;

  // RAM address width for a power-of-two depth.
  function automatic int calc_addr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Default almost-full threshold: two entries short of full.
  function automatic int af_default(input int depth);
    return depth - 2;
  endfunction

  // Binary to reflected Gray code; callers zero-extend and truncate.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Gray to binary via prefix XOR from the MSB downwards.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = gray;
    for (int s = 1; s < 32; s = s * 2) begin
      bin = bin ^ (bin >> s);
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bundle between the producer/FIFO top and the write controller.
// Handshake: winc is a request that is held only for the cycle it is meant;
// wen in the same cycle is the acknowledge (winc & ~wfull), and the RAM write
// plus pointer advance both happen on the edge that closes that cycle. A
// request seen while wfull is high is dropped and recorded in woverflow.
interface fifo_wr_ctrl_if #(
  parameter int ADDR_WIDTH = 3
);
  logic                  winc;
  logic                  wclr_ovf;
  logic [ADDR_WIDTH:0]   rq2_rptr;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH:0]   wptr;
  logic                  wfull;
  logic                  walmost_full;
  logic [ADDR_WIDTH:0]   wlevel;
  logic                  woverflow;

  modport master (
    output winc, wclr_ovf, rq2_rptr,
    input  wen, waddr, wptr, wfull, walmost_full, wlevel, woverflow
  );

  modport slave (
    input  winc, wclr_ovf, rq2_rptr,
    output wen, waddr, wptr, wfull, walmost_full, wlevel, woverflow
  );
endinterface

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at and above it.
module fifo_gray2bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  // Prefix XOR per bit, written without a self-referencing chain.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[W-1:i];
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-domain pointer and flag controller of the async FIFO. Keeps the
// binary write count, drives the RAM write port, publishes a registered Gray
// pointer for the read-domain synchroniser and derives full, almost-full,
// level and sticky overflow from the synchronised read pointer.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = calc_addr_width(FIFO_DEPTH),
  parameter int AF_THRESH  = af_default(FIFO_DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  fifo_wr_ctrl_if.slave  bus
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] AF_T = PW'(AF_THRESH);

  logic [ADDR_WIDTH:0]   wbin_q, wbin_d;
  logic [ADDR_WIDTH:0]   wgray_q, wgray_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                  wfull_q, wfull_d;
  logic                  waf_q, waf_d;
  logic [ADDR_WIDTH:0]   wlevel_q, wlevel_d;
  logic                  wovf_q, wovf_d;
  logic [ADDR_WIDTH:0]   rbin;
  logic [ADDR_WIDTH:0]   full_match;
  logic                  accept;

  fifo_gray2bin #(.W(PW)) u_rptr_g2b (
    .gray_i (bus.rq2_rptr),
    .bin_o  (rbin)
  );

  // Writes are accepted only against the registered full flag, so a slot
  // freed this cycle cannot be reused until the next one.
  assign accept = bus.winc & ~wfull_q;

  // Full when the next write pointer equals the read pointer with the top two
  // Gray bits inverted (same address, one lap ahead).
  assign full_match = {~bus.rq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1],
                       bus.rq2_rptr[ADDR_WIDTH-2:0]};

  // Next-state for pointers, flags and the sticky overflow bit.
  always_comb begin
    wbin_d   = wbin_q + {{ADDR_WIDTH{1'b0}}, accept};
    wgray_d  = PW'(bin2gray(32'(wbin_d)));
    waddr_d  = wbin_d[ADDR_WIDTH-1:0];
    wfull_d  = (wgray_d == full_match);
    wlevel_d = wbin_d - rbin;
    waf_d    = (wlevel_d >= AF_T);
    wovf_d   = wovf_q;
    if (bus.winc && wfull_q) begin
      wovf_d = 1'b1;
    end else if (bus.wclr_ovf) begin
      wovf_d = 1'b0;
    end
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      waddr_q  <= '0;
      wfull_q  <= 1'b0;
      waf_q    <= 1'b0;
      wlevel_q <= '0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      waddr_q  <= waddr_d;
      wfull_q  <= wfull_d;
      waf_q    <= waf_d;
      wlevel_q <= wlevel_d;
      wovf_q   <= wovf_d;
    end
  end

  assign bus.wen          = accept;
  assign bus.waddr        = waddr_q;
  assign bus.wptr         = wgray_q;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = waf_q;
  assign bus.wlevel       = wlevel_q;
  assign bus.woverflow    = wovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl at FIFO_DEPTH=8, AF_THRESH=6. The reference model
// counts writes and reads as plain integers; Gray codes come from a table
// built by reflection.
module tb_fifo_wr_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int AFT   = 6;

  logic clk;
  logic rst;

  fifo_wr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_wr_ctrl #(.FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW), .AF_THRESH(AFT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model and scoreboard ----------------
  int          n_cmp;
  int          n_fail;
  int          m_wr;
  int          m_rd;
  bit          m_full;
  bit          m_ovf;
  bit          m_acc;
  logic [3:0]  gtab [16];
  logic [AW:0] exp_q [$];

  function automatic logic [3:0] g_of(input int n);
    return gtab[n % 16];
  endfunction

  function automatic int lvl();
    return m_wr - m_rd;
  endfunction

  task automatic build_gray_table();
    gtab[0] = 4'd0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < (1 << k); i++) begin
        gtab[(2 << k) - 1 - i] = gtab[i] | 4'((1 << k));
      end
    end
  endtask

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_full = 0; m_ovf = 0; m_acc = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input bit w, input bit clr, input int rd);
    @(negedge clk);
    bus.winc     = w;
    bus.wclr_ovf = clr;
    m_rd         = rd;
    bus.rq2_rptr = g_of(rd);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    m_acc = bus.winc && !m_full;
    if (bus.winc && m_full) m_ovf = 1;
    else if (bus.wclr_ovf) m_ovf = 0;
    if (m_acc) m_wr++;
    m_full = (lvl() == DEPTH);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.winc = 0; bus.wclr_ovf = 0; bus.rq2_rptr = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_cmp++; if (bus.wptr !== 4'b0000) begin n_fail++; $display("FAIL reset_wptr got=%b exp=0000", bus.wptr); end
    n_cmp++; if (bus.waddr !== 3'd0) begin n_fail++; $display("FAIL reset_waddr got=%0d exp=0", bus.waddr); end
    n_cmp++; if (bus.wfull !== 1'b0) begin n_fail++; $display("FAIL reset_wfull got=%b exp=0", bus.wfull); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    // Burst of writes, then reset lands asynchronously mid-burst.
    for (int i = 0; i < 3; i++) begin
      set_inputs(1, 0, 0);
      tick();
    end
    n_cmp++; if (bus.wlevel !== 4'(lvl())) begin n_fail++; $display("FAIL burst_level got=%0d exp=%0d", bus.wlevel, lvl()); end
    set_inputs(1, 0, 0);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.wptr !== 4'b0000) begin n_fail++; $display("FAIL midrst_wptr got=%b exp=0000", bus.wptr); end
    n_cmp++; if (bus.waddr !== 3'd0) begin n_fail++; $display("FAIL midrst_waddr got=%0d exp=0", bus.waddr); end
    n_cmp++; if (bus.wfull !== 1'b0) begin n_fail++; $display("FAIL midrst_wfull got=%b exp=0", bus.wfull); end
    n_cmp++; if (bus.wlevel !== 4'd0) begin n_fail++; $display("FAIL midrst_wlevel got=%0d exp=0", bus.wlevel); end
    n_cmp++; if (bus.woverflow !== 1'b0) begin n_fail++; $display("FAIL midrst_wovf got=%b exp=0", bus.woverflow); end
    @(posedge clk); #1;
    n_cmp++; if (bus.wptr !== 4'b0000) begin n_fail++; $display("FAIL rst_hold_wptr got=%b exp=0000", bus.wptr); end
    @(negedge clk);
    bus.winc = 0;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_fill();
    for (int k = 1; k <= DEPTH; k++) begin
      set_inputs(1, 0, 0);
      n_cmp++; if (bus.wen !== 1'b1) begin n_fail++; $display("FAIL fill_wen k=%0d got=%b exp=1", k, bus.wen); end
      tick();
      n_cmp++; if (bus.waddr !== 3'(m_wr % DEPTH)) begin n_fail++; $display("FAIL fill_waddr k=%0d got=%0d exp=%0d", k, bus.waddr, m_wr % DEPTH); end
      n_cmp++; if (bus.wptr !== g_of(m_wr)) begin n_fail++; $display("FAIL fill_wptr k=%0d got=%b exp=%b", k, bus.wptr, g_of(m_wr)); end
      n_cmp++; if (bus.walmost_full !== (lvl() >= AFT)) begin n_fail++; $display("FAIL fill_af k=%0d got=%b exp=%b", k, bus.walmost_full, lvl() >= AFT); end
      n_cmp++; if (bus.wfull !== m_full) begin n_fail++; $display("FAIL fill_wfull k=%0d got=%b exp=%b", k, bus.wfull, m_full); end
      n_cmp++; if (bus.wlevel !== 4'(lvl())) begin n_fail++; $display("FAIL fill_level k=%0d got=%0d exp=%0d", k, bus.wlevel, lvl()); end
    end
    n_cmp++; if (bus.wptr !== 4'b1100) begin n_fail++; $display("FAIL fill_final_wptr got=%b exp=1100", bus.wptr); end
    n_cmp++; if (bus.wfull !== 1'b1) begin n_fail++; $display("FAIL fill_final_full got=%b exp=1", bus.wfull); end
  endtask

  task automatic test_overflow();
    set_inputs(1, 0, 0);
    n_cmp++; if (bus.wen !== 1'b0) begin n_fail++; $display("FAIL ovf_wen got=%b exp=0", bus.wen); end
    tick();
    n_cmp++; if (bus.waddr !== 3'd0) begin n_fail++; $display("FAIL ovf_waddr got=%0d exp=0", bus.waddr); end
    n_cmp++; if (bus.wptr !== 4'b1100) begin n_fail++; $display("FAIL ovf_wptr got=%b exp=1100", bus.wptr); end
    n_cmp++; if (bus.woverflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", bus.woverflow); end
    set_inputs(0, 1, 0);
    tick();
    n_cmp++; if (bus.woverflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0", bus.woverflow); end
    set_inputs(1, 1, 0);
    tick();
    n_cmp++; if (bus.woverflow !== m_ovf) begin n_fail++; $display("FAIL ovf_set_wins got=%b exp=%b", bus.woverflow, m_ovf); end
    set_inputs(0, 0, 0);
    tick();
    n_cmp++; if (bus.woverflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", bus.woverflow); end
    set_inputs(0, 1, 0);
    tick();
  endtask

  task automatic test_release();
    set_inputs(0, 0, 1);
    tick();
    n_cmp++; if (bus.wfull !== 1'b0) begin n_fail++; $display("FAIL rel_wfull got=%b exp=0", bus.wfull); end
    n_cmp++; if (bus.wlevel !== 4'd7) begin n_fail++; $display("FAIL rel_level got=%0d exp=7", bus.wlevel); end
    set_inputs(1, 0, 1);
    n_cmp++; if (bus.wen !== 1'b1) begin n_fail++; $display("FAIL rel_wen got=%b exp=1", bus.wen); end
    tick();
    n_cmp++; if (bus.wfull !== 1'b1) begin n_fail++; $display("FAIL rel_refull got=%b exp=1", bus.wfull); end
    n_cmp++; if (bus.wptr !== 4'b1101) begin n_fail++; $display("FAIL rel_wptr got=%b exp=1101", bus.wptr); end
  endtask

  task automatic test_wrap();
    logic [AW:0] e;
    do_reset();
    for (int k = 1; k <= 20; k++) exp_q.push_back(g_of(k));
    for (int k = 0; k < 20; k++) begin
      set_inputs(1, 0, (m_wr > 0) ? m_wr - 1 : 0);
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (bus.wptr !== e) begin n_fail++; $display("FAIL wrap_wptr k=%0d got=%b exp=%b", k, bus.wptr, e); end
      n_cmp++; if (bus.wfull !== 1'b0) begin n_fail++; $display("FAIL wrap_wfull k=%0d got=%b exp=0", k, bus.wfull); end
      n_cmp++; if (bus.wlevel > 4'd2 || bus.wlevel !== 4'(lvl())) begin n_fail++; $display("FAIL wrap_level k=%0d got=%0d exp=%0d", k, bus.wlevel, lvl()); end
    end
  endtask

  task automatic test_random();
    int          wr_h1;
    int          wr_h2;
    int          rd_next;
    logic [AW:0] prev;
    do_reset();
    wr_h1 = 0; wr_h2 = 0;
    for (int c = 0; c < 600; c++) begin
      rd_next = m_rd + int'($urandom_range(0, wr_h2 - m_rd));
      if ($urandom_range(0, 3) == 0) rd_next = m_rd;
      set_inputs(($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0), rd_next);
      n_cmp++; if (bus.wen !== (bus.winc && !m_full)) begin n_fail++; $display("FAIL rnd_wen c=%0d got=%b exp=%b", c, bus.wen, bus.winc && !m_full); end
      prev = bus.wptr;
      tick();
      wr_h2 = wr_h1; wr_h1 = m_wr;
      n_cmp++; if ($countones(prev ^ bus.wptr) != (m_acc ? 1 : 0)) begin n_fail++; $display("FAIL rnd_onebit c=%0d got=%b prev=%b acc=%0d", c, bus.wptr, prev, m_acc); end
      n_cmp++; if (bus.wptr !== g_of(m_wr)) begin n_fail++; $display("FAIL rnd_wptr c=%0d got=%b exp=%b", c, bus.wptr, g_of(m_wr)); end
      n_cmp++; if (bus.waddr !== 3'(m_wr % DEPTH)) begin n_fail++; $display("FAIL rnd_waddr c=%0d got=%0d exp=%0d", c, bus.waddr, m_wr % DEPTH); end
      n_cmp++; if (bus.wfull !== m_full) begin n_fail++; $display("FAIL rnd_wfull c=%0d got=%b exp=%b", c, bus.wfull, m_full); end
      n_cmp++; if (bus.wlevel !== 4'(lvl())) begin n_fail++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, bus.wlevel, lvl()); end
      n_cmp++; if (bus.walmost_full !== (lvl() >= AFT)) begin n_fail++; $display("FAIL rnd_af c=%0d got=%b exp=%b", c, bus.walmost_full, lvl() >= AFT); end
      n_cmp++; if (bus.woverflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf c=%0d got=%b exp=%b", c, bus.woverflow, m_ovf); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_fail = 0;
    build_gray_table();
    model_reset();
    rst = 1'b1;
    bus.winc = 0; bus.wclr_ovf = 0; bus.rq2_rptr = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_overflow();
    test_release();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
